// File: rtl/delay_line.sv
// Tapped shift register: DEPTH stages of WIDTH bits with a runtime tap select,
// a saturating fill count for output qualification, and an optional output register.
module delay_line #(
  parameter int    WIDTH   = 1,
  parameter int    DEPTH   = 4,
  parameter string OUT_REG = "FALSE",
  localparam int   TAP_W   = $clog2(DEPTH)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             EN,
  input  logic             CLR,
  input  logic [TAP_W-1:0] TAP,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             Q_VALID,
  output logic             FULL
);

  localparam int                FILL_W   = $clog2(DEPTH + 1);
  localparam logic [TAP_W-1:0]  TAP_MAX  = TAP_W'(DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

  logic [WIDTH-1:0]  stage    [DEPTH];
  logic [WIDTH-1:0]  shift_in [DEPTH];
  logic [FILL_W-1:0] fill;
  logic [TAP_W-1:0]  tap_sel;
  logic [WIDTH-1:0]  q_mux;
  logic              valid_mux;

  // Next value of each stage: D enters stage 0, everything else moves up by one.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign shift_in[i] = D;
    end else begin : g_body
      assign shift_in[i] = stage[i-1];
    end
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (CLR) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (EN) begin
      stage <= shift_in;
    end
  end

  // Fill count saturates at DEPTH; it is the only control state in the block.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      fill <= '0;
    end else if (CLR) begin
      fill <= '0;
    end else if (EN && (fill != FILL_MAX)) begin
      fill <= fill + 1'b1;
    end
  end

  // Taps beyond the last stage only exist when DEPTH is not a power of two.
  if (DEPTH == (2 ** TAP_W)) begin : g_tap_direct
    assign tap_sel = TAP;
  end else begin : g_tap_clamp
    assign tap_sel = (TAP > TAP_MAX) ? TAP_MAX : TAP;
  end

  assign q_mux     = stage[tap_sel];
  assign valid_mux = (32'(fill) > 32'(tap_sel));
  assign FULL      = (fill == FILL_MAX);

  if (OUT_REG == "TRUE") begin : g_out_reg
    logic [WIDTH-1:0] q_r;
    logic             valid_r;

    // Samples every edge, independent of EN, so a tap change shows one edge later.
    always_ff @(posedge CK or posedge RST) begin
      if (RST) begin
        q_r     <= '0;
        valid_r <= 1'b0;
      end else if (CLR) begin
        q_r     <= '0;
        valid_r <= 1'b0;
      end else begin
        q_r     <= q_mux;
        valid_r <= valid_mux;
      end
    end

    assign Q       = q_r;
    assign Q_VALID = valid_r;
  end else begin : g_out_comb
    assign Q       = q_mux;
    assign Q_VALID = valid_mux;
  end

endmodule

// File: tb/tb_delay_line.sv
// Directed bench for delay_line: combinational-output, registered-output and
// non-power-of-two (tap clamp) instances driven from shared inputs.
module tb_delay_line;

  logic       CK = 1'b0;
  logic       RST, EN, CLR;
  logic [1:0] TAP;
  logic [7:0] D;

  logic [7:0] q_c, q_r, q_n;
  logic       qv_c, qv_r, qv_n;
  logic       full_c, full_r, full_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] sweep_exp [4] = '{8'h44, 8'h33, 8'h22, 8'h11};
  logic [7:0] hold_d    [3] = '{8'hA5, 8'h5A, 8'hFF};

  always #5 CK = ~CK;

  delay_line #(.WIDTH(8), .DEPTH(4), .OUT_REG("FALSE")) dut_c (
    .CK(CK), .RST(RST), .EN(EN), .CLR(CLR), .TAP(TAP), .D(D),
    .Q(q_c), .Q_VALID(qv_c), .FULL(full_c)
  );

  delay_line #(.WIDTH(8), .DEPTH(4), .OUT_REG("TRUE")) dut_r (
    .CK(CK), .RST(RST), .EN(EN), .CLR(CLR), .TAP(TAP), .D(D),
    .Q(q_r), .Q_VALID(qv_r), .FULL(full_r)
  );

  delay_line #(.WIDTH(8), .DEPTH(3), .OUT_REG("FALSE")) dut_n (
    .CK(CK), .RST(RST), .EN(EN), .CLR(CLR), .TAP(TAP), .D(D),
    .Q(q_n), .Q_VALID(qv_n), .FULL(full_n)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  // Empty line, TAP=3, D = 11..55 on successive enabled edges.
  task automatic run_fill(input string pfx);
    TAP = 2'd3; EN = 1'b1; CLR = 1'b0;
    D = 8'h11; tick();
    check({pfx, " e1 q_c"}, q_c, 8'h00);
    check({pfx, " e1 qv_c"}, {7'd0, qv_c}, 8'h00);
    check({pfx, " e1 full_c"}, {7'd0, full_c}, 8'h00);
    check({pfx, " e1 q_r"}, q_r, 8'h00);
    D = 8'h22; tick();
    check({pfx, " e2 qv_c"}, {7'd0, qv_c}, 8'h00);
    check({pfx, " e2 full_c"}, {7'd0, full_c}, 8'h00);
    D = 8'h33; tick();
    check({pfx, " e3 qv_c"}, {7'd0, qv_c}, 8'h00);
    check({pfx, " e3 qv_r"}, {7'd0, qv_r}, 8'h00);
    D = 8'h44; tick();
    check({pfx, " e4 q_c"}, q_c, 8'h11);
    check({pfx, " e4 qv_c"}, {7'd0, qv_c}, 8'h01);
    check({pfx, " e4 full_c"}, {7'd0, full_c}, 8'h01);
    check({pfx, " e4 q_r"}, q_r, 8'h00);
    check({pfx, " e4 qv_r"}, {7'd0, qv_r}, 8'h00);
    D = 8'h55; tick();
    check({pfx, " e5 q_c"}, q_c, 8'h22);
    check({pfx, " e5 qv_c"}, {7'd0, qv_c}, 8'h01);
    check({pfx, " e5 q_r"}, q_r, 8'h11);
    check({pfx, " e5 qv_r"}, {7'd0, qv_r}, 8'h01);
    check({pfx, " e5 full_r"}, {7'd0, full_r}, 8'h01);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; TAP = 2'd3; D = 8'h00;
    #2;
    check("reset q_c", q_c, 8'h00);
    check("reset qv_c", {7'd0, qv_c}, 8'h00);
    check("reset full_c", {7'd0, full_c}, 8'h00);
    check("reset q_r", q_r, 8'h00);
    check("reset qv_r", {7'd0, qv_r}, 8'h00);
    tick();
    tick();
    RST = 1'b0;

    run_fill("fill");

    // Hold: line is [55,44,33,22], stage 3 visible.
    EN = 1'b0;
    for (int i = 0; i < 3; i++) begin
      D = hold_d[i]; tick();
      check("hold q_c", q_c, 8'h22);
      check("hold full_c", {7'd0, full_c}, 8'h01);
      check("hold q_r", q_r, 8'h22);
    end
    EN = 1'b1;
    D = 8'h66; tick();
    check("resume1 q_c", q_c, 8'h33);
    check("resume1 q_r", q_r, 8'h22);
    D = 8'h77; tick();
    check("resume2 q_c", q_c, 8'h44);
    check("resume2 q_r", q_r, 8'h33);

    // Clear wins over enable.
    CLR = 1'b1; EN = 1'b1; D = 8'hAA; tick();
    check("clr q_c", q_c, 8'h00);
    check("clr qv_c", {7'd0, qv_c}, 8'h00);
    check("clr full_c", {7'd0, full_c}, 8'h00);
    check("clr q_r", q_r, 8'h00);
    check("clr qv_r", {7'd0, qv_r}, 8'h00);
    check("clr full_n", {7'd0, full_n}, 8'h00);
    CLR = 1'b0; EN = 1'b0; TAP = 2'd0; #1;
    check("clr fill0 qv_c", {7'd0, qv_c}, 8'h00);
    EN = 1'b1; D = 8'hAA; tick();
    check("after clr q_c", q_c, 8'hAA);
    check("after clr qv_c", {7'd0, qv_c}, 8'h01);
    check("after clr q_r", q_r, 8'h00);
    EN = 1'b0; tick();
    check("after clr q_r late", q_r, 8'hAA);
    check("after clr qv_r late", {7'd0, qv_r}, 8'h01);

    // Refill with 11..44 so stage 0 = 44 and stage 3 = 11.
    CLR = 1'b1; tick();
    CLR = 1'b0; EN = 1'b1;
    D = 8'h11; tick();
    D = 8'h22; tick();
    D = 8'h33; tick();
    D = 8'h44; tick();
    EN = 1'b0;
    check("depth3 full_n", {7'd0, full_n}, 8'h01);
    for (int t = 0; t < 4; t++) begin
      TAP = 2'(t); #1;
      check("sweep q_c", q_c, sweep_exp[t]);
      check("sweep qv_c", {7'd0, qv_c}, 8'h01);
      if (t >= 2) begin
        check("clamp q_n", q_n, 8'h22);
        check("clamp qv_n", {7'd0, qv_n}, 8'h01);
      end
      tick();
      check("sweep q_r", q_r, sweep_exp[t]);
      check("sweep qv_r", {7'd0, qv_r}, 8'h01);
    end

    // Asynchronous reset between edges on a full line.
    #2;
    RST = 1'b1; #1;
    check("async q_c", q_c, 8'h00);
    check("async qv_c", {7'd0, qv_c}, 8'h00);
    check("async full_c", {7'd0, full_c}, 8'h00);
    check("async q_r", q_r, 8'h00);
    check("async qv_r", {7'd0, qv_r}, 8'h00);
    check("async full_n", {7'd0, full_n}, 8'h00);
    RST = 1'b0;

    run_fill("refill");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/delay_line.md
DELAY_LINE -- requirements
Module: delay_line

Interface
REQ-001 Parameter WIDTH, default 1: data bits per stage; SHALL be >= 1.
REQ-002 Parameter DEPTH, default 4: number of register stages; SHALL be >= 2.
REQ-003 Parameter OUT_REG, default "FALSE": "TRUE" SHALL add one output register after the tap mux.
REQ-004 Localparam TAP_W SHALL equal $clog2(DEPTH).
REQ-005 CK  input  1  the single clock; all state SHALL update on its rising edge only.
REQ-006 RST  input  1  reset, asynchronous and active-high.
REQ-007 EN  input  1  shift enable; when 0, the stage contents and the fill count SHALL hold.
REQ-008 CLR  input  1  synchronous clear of all stages and of the fill count.
REQ-009 TAP  input  TAP_W  runtime tap select; stage index 0..DEPTH-1.
REQ-010 D  input  WIDTH  data into stage 0.
REQ-011 Q  output  WIDTH  data from the selected stage.
REQ-012 Q_VALID  output  1  high when Q holds data that was shifted in since the last reset or clear.
REQ-013 FULL  output  1  high when all DEPTH stages hold shifted-in data.

Function
REQ-014 On each edge with EN=1 and CLR=0: stage[0] SHALL load D, and each stage[i] SHALL load stage[i-1] for i = 1..DEPTH-1.
REQ-015 Every stage SHALL update simultaneously (true register chain); D SHALL never reach stage[i>0] on the edge that captures it.
REQ-016 The fill counter SHALL increment on each enabled shift and saturate at DEPTH; it SHALL be DEPTH+1 states wide, 0..DEPTH.
REQ-017 FULL SHALL be 1 exactly when fill == DEPTH.
REQ-018 TAP values >= DEPTH (non-power-of-2 DEPTH) SHALL be clamped to DEPTH-1.
REQ-019 With OUT_REG="FALSE": Q = stage[TAP] combinationally, and Q_VALID = (fill >= TAP+1) combinationally.
REQ-020 With OUT_REG="FALSE": a D word captured at enabled edge k SHALL appear on Q after the TAP-th subsequent enabled edge, i.e. TAP+1 enabled edges in total.
REQ-021 With OUT_REG="TRUE": Q and Q_VALID SHALL be registered copies of the REQ-019 values, updated every edge regardless of EN, adding exactly one CK of latency.
REQ-022 A TAP change SHALL take effect on Q and Q_VALID immediately (OUT_REG="FALSE") or after one edge (OUT_REG="TRUE"), with no effect on the stage contents.
REQ-023 CLR=1 SHALL zero all stages, the fill count and any output register on the next edge, and SHALL take priority over EN=1 in the same cycle.
REQ-024 The block SHALL have no other state machine; the fill counter is its only control state.

Reset
REQ-025 Asserting RST SHALL immediately, without a clock edge, force: all stages = 0, fill = 0, Q = 0, Q_VALID = 0, FULL = 0.
REQ-026 RST asserted mid-stream SHALL discard all in-flight data; after release, operation SHALL resume from the empty state.
REQ-027 The first edge after RST release SHALL act normally: an enabled shift on that edge SHALL capture D.

Structure
REQ-028 No shared package SHALL be required; TAP_W and the clamp logic SHALL be local to delay_line.
REQ-029 The stages SHALL be a single WIDTH x DEPTH array built with a generate/for loop; no sub-module SHALL be used.

Verification
REQ-030 Use WIDTH=8, DEPTH=4, TAP=3, OUT_REG="FALSE", EN=1, and D = 0x11, 0x22, 0x33, 0x44, 0x55 on successive edges. Required: Q = 0x11 after the 4th edge, with Q_VALID rising at the same point, FULL=1, then Q = 0x22.
REQ-031 Repeat REQ-030 with OUT_REG="TRUE". Required: Q = 0x11 and Q_VALID=1 one edge later than in REQ-030.
REQ-032 Fill the line, then hold EN=0 for 3 edges while D toggles. Required: Q, stages and FULL unchanged; on resuming EN, the shift continues in order.
REQ-033 With the line full of 0x11..0x44, sweep TAP 0->3. Required: Q = 0x44, 0x33, 0x22, 0x11 in turn; Q_VALID stays 1.
REQ-034 Drive CLR=1 and EN=1 together with D=0xAA. Required: all outputs are 0 after the edge and fill = 0; with TAP=0, the next enabled shift gives Q=0xAA and Q_VALID=1.
REQ-035 Pulse RST between clock edges while the line is full. Required: Q, Q_VALID and FULL go to 0 before the next edge; the REQ-030 sequence then repeats identically.
